// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: ALU execute stage; single-cycle add/sub/and/or/slt plus optional shift-add mult.
// Define ALU_EXEC_CTRL_MUL_EN to build mult (funct 0x18); without it that funct decodes as illegal.
module alu_exec_ctrl #(
    parameter int WIDTH     = 32,
    parameter int MUL_CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUOp_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic [3:0]       ALUCtrl_o,
    output logic             illegal_o
);
    localparam logic [3:0] C_AND = 4'd0, C_OR = 4'd1, C_ADD = 4'd2, C_MUL = 4'd3;
    localparam logic [3:0] C_SUB = 4'd6, C_SLT = 4'd7, C_ILL = 4'hF;

    if (2 ** MUL_CNT_W < WIDTH) begin : g_bad_cnt
        $error("MUL_CNT_W too narrow for WIDTH");
    end

    logic [3:0]       w_ctrl;
    logic [WIDTH-1:0] w_res;
    logic             w_accept;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [3:0]       r_ctrl;
    logic             r_illegal;

    always_comb begin
        w_ctrl = C_ILL;
        case (ALUOp_i)
            3'd1: case (funct_i)
                6'h20: w_ctrl = C_ADD;
                6'h22: w_ctrl = C_SUB;
                6'h24: w_ctrl = C_AND;
                6'h25: w_ctrl = C_OR;
                6'h2A: w_ctrl = C_SLT;
`ifdef ALU_EXEC_CTRL_MUL_EN
                6'h18: w_ctrl = C_MUL;
`endif
                default: w_ctrl = C_ILL;
            endcase
            3'd2, 3'd5, 3'd6: w_ctrl = C_ADD;
            3'd3: w_ctrl = C_SLT;
            3'd4: w_ctrl = C_SUB;
            default: w_ctrl = C_ILL;
        endcase
    end

    // Illegal (and mult, which completes elsewhere) fall through to zero.
    assign w_res = (w_ctrl == C_ADD) ? src1_i + src2_i :
                   (w_ctrl == C_SUB) ? src1_i - src2_i :
                   (w_ctrl == C_AND) ? src1_i & src2_i :
                   (w_ctrl == C_OR)  ? src1_i | src2_i :
                   (w_ctrl == C_SLT) ? {{(WIDTH-1){1'b0}}, $signed(src1_i) < $signed(src2_i)} : '0;

    assign w_accept = valid_i && ready_o;

`ifdef ALU_EXEC_CTRL_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [MUL_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     w_acc_nxt;
    logic                 w_last;
    logic                 w_mul_done;

    assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last     = r_cnt == MUL_CNT_W'(WIDTH - 1);
    assign w_mul_done = (r_state == S_MUL) && w_last;
    assign ready_o    = (r_state == S_IDLE) && !rst_i;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_IDLE && w_accept && w_ctrl == C_MUL)
            w_state_nxt = S_MUL;
        else if (w_mul_done)
            w_state_nxt = S_IDLE;
    end

    // One shift-add step per MUL cycle; operand registers need no reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_MUL) begin
                r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end else if (w_accept) begin
                r_cnt    <= '0;
                r_acc    <= '0;
                r_mcand  <= src1_i;
                r_mplier <= src2_i;
            end
        end
    end
`else
    assign ready_o = !rst_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_ctrl    <= 4'd0;
            r_illegal <= 1'b0;
`ifdef ALU_EXEC_CTRL_MUL_EN
        end else if (w_mul_done) begin
            r_valid   <= 1'b1;
            r_result  <= w_acc_nxt;
            r_zero    <= w_acc_nxt == '0;
            r_ctrl    <= C_MUL;
            r_illegal <= 1'b0;
`endif
        end else if (w_accept && w_ctrl != C_MUL) begin
            r_valid   <= 1'b1;
            r_result  <= w_res;
            r_zero    <= w_res == '0;
            r_ctrl    <= w_ctrl;
            r_illegal <= w_ctrl == C_ILL;
        end else begin
            r_valid   <= 1'b0;
        end
    end

    assign valid_o   = r_valid;
    assign result_o  = r_result;
    assign zero_o    = r_zero;
    assign ALUCtrl_o = r_ctrl;
    assign illegal_o = r_illegal;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed and random stimulus against a behavioural model of alu_exec_ctrl.
module tb_alu_exec_ctrl;
`ifdef ALU_EXEC_CTRL_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  ALUOp_i = '0;
    logic [5:0]  funct_i = '0;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic        valid_o;
    logic [31:0] result_o;
    logic        zero_o;
    logic [3:0]  ALUCtrl_o;
    logic        illegal_o;

    int n_checks = 0;
    int n_errors = 0;

    int          m_left = 0;
    logic [31:0] m_pend = '0;
    logic        e_valid = 1'b0;
    logic [31:0] e_res = '0;
    logic        e_zero = 1'b0;
    logic [3:0]  e_ctrl = '0;
    logic        e_ill = 1'b0;

    alu_exec_ctrl #(.WIDTH(32), .MUL_CNT_W(6)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .ALUOp_i(ALUOp_i), .funct_i(funct_i), .src1_i(src1_i), .src2_i(src2_i),
        .valid_o(valid_o), .result_o(result_o), .zero_o(zero_o),
        .ALUCtrl_o(ALUCtrl_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void ref_op(input logic [2:0] op, input logic [5:0] fn,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [3:0] c, output logic [31:0] r);
        logic [63:0] p;
        c = 4'hF;
        if (op == 3'd1) begin
            if (fn == 6'h20) c = 4'd2;
            else if (fn == 6'h22) c = 4'd6;
            else if (fn == 6'h24) c = 4'd0;
            else if (fn == 6'h25) c = 4'd1;
            else if (fn == 6'h2A) c = 4'd7;
            else if (fn == 6'h18 && MUL_EN) c = 4'd3;
        end else if (op == 3'd2 || op == 3'd5 || op == 3'd6) c = 4'd2;
        else if (op == 3'd3) c = 4'd7;
        else if (op == 3'd4) c = 4'd6;
        p = {32'd0, a} * {32'd0, b};
        case (c)
            4'd2: r = a + b;
            4'd6: r = a - b;
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3: r = p[31:0];
            default: r = 32'd0;
        endcase
    endfunction

    task automatic cyc(input logic v, input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic r);
        logic [3:0]  c;
        logic [31:0] res;
        valid_i = v; ALUOp_i = op; funct_i = fn; src1_i = a; src2_i = b; rst_i = r;
        #1 chk("ready", ready_o, !r && m_left == 0);
        @(posedge clk);
        if (r) begin
            m_left = 0; e_valid = 0; e_res = 0; e_zero = 0; e_ctrl = 0; e_ill = 0;
        end else begin
            e_valid = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    e_valid = 1; e_res = m_pend; e_zero = m_pend == 0; e_ctrl = 4'd3; e_ill = 0;
                end
            end else if (v) begin
                ref_op(op, fn, a, b, c, res);
                if (c == 4'd3) begin
                    m_left = 32; m_pend = res;
                end else begin
                    e_valid = 1; e_res = res; e_zero = res == 0; e_ctrl = c; e_ill = c == 4'hF;
                end
            end
        end
        #1;
        chk("valid", valid_o, e_valid);
        chk("result", result_o, e_res);
        chk("zero", zero_o, e_zero);
        chk("ctrl", ALUCtrl_o, e_ctrl);
        chk("illegal", illegal_o, e_ill);
    endtask

    function automatic logic [5:0] pick_fn();
        case ($urandom_range(0, 6))
            0: return 6'h20;
            1: return 6'h22;
            2: return 6'h24;
            3: return 6'h25;
            4: return 6'h2A;
            5: return 6'h18;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        logic [2:0]  op;
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_ctrl", ALUCtrl_o, 0);

        cyc(1, 1, 6'h22, 5, 7, 0);
        chk("sub_valid", valid_o, 1);
        chk("sub_res", result_o, 32'hFFFFFFFE);
        chk("sub_ctrl", ALUCtrl_o, 6);
        chk("sub_zero", zero_o, 0);

        cyc(1, 3, 0, 32'hFFFFFFFF, 1, 0);
        chk("slti_res", result_o, 1);
        chk("slti_ctrl", ALUCtrl_o, 7);
        cyc(1, 4, 0, 9, 9, 0);
        chk("beq_valid", valid_o, 1);
        chk("beq_res", result_o, 0);
        chk("beq_zero", zero_o, 1);

        cyc(1, 7, 0, 3, 4, 0);
        chk("ill7_flag", illegal_o, 1);
        chk("ill7_ctrl", ALUCtrl_o, 4'hF);
        chk("ill7_res", result_o, 0);
        cyc(1, 1, 6'h00, 3, 4, 0);
        chk("illf_flag", illegal_o, 1);
        chk("illf_zero", zero_o, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("hold_valid", valid_o, 0);
        chk("hold_flag", illegal_o, 1);

        cyc(1, 1, 6'h18, 32'h10001, 32'h10001, 0);
        if (MUL_EN) begin
            for (int i = 0; i < 31; i++) cyc(1, 2, 0, $urandom, $urandom, 0);
            cyc(1, 2, 0, 1, 1, 0);
            chk("mul_valid", valid_o, 1);
            chk("mul_res", result_o, 32'h00020001);
            chk("mul_ctrl", ALUCtrl_o, 3);
            cyc(1, 2, 0, 1, 1, 0);
            chk("post_mul_add", result_o, 2);

            cyc(1, 1, 6'h18, 32'h1234, 32'h5678, 0);
            for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 0);
            cyc(1, 2, 0, 1, 1, 1);
            chk("mrst_valid", valid_o, 0);
            chk("mrst_result", result_o, 0);
            for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 0, 0);
            chk("mrst_quiet", valid_o, 0);
        end else begin
            chk("nomul_ill", illegal_o, 1);
            chk("nomul_ctrl", ALUCtrl_o, 4'hF);
            chk("nomul_res", result_o, 0);
        end

        for (int i = 0; i < 700; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 4) == 0) a = $urandom_range(0, 3);
            op = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
            cyc($urandom_range(0, 9) < 7, op, pick_fn(), a, b, $urandom_range(0, 99) < 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
